// File: rtl/div_seq.sv
// Iterative restoring radix-2 integer divider, one quotient bit per clock.
// Optional per-operation signed mode, divide-by-zero flag, valid/ready on both sides.
module div_seq #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] raw_dvd_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             rneg_q;

    logic             sgn;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes fit in WIDTH unsigned bits, including |MIN| = 2^(WIDTH-1).
    always_comb begin
        sgn     = is_signed && SIGNED_EN;
        dvd_abs = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_bit   = ~diff[WIDTH];
        quo_fix = neg_q  ? -quo_q : quo_q;
        rem_fix = rneg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt_q == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            raw_dvd_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q       <= dvd_abs;
                        dvs_q       <= dvs_abs;
                        raw_dvd_q   <= dividend;
                        rem_q       <= '0;
                        quo_q       <= '0;
                        cnt_q       <= CW'(WIDTH - 1);
                        neg_q       <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_q      <= sgn && dividend[WIDTH-1];
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    quotient  <= quo_fix;
                    remainder <= rem_fix;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // Entering DONE with out_valid low only happens on the zero-divisor path.
                    if (!out_valid) begin
                        quotient    <= '1;
                        remainder   <= raw_dvd_q;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: a 32-bit signed-capable instance
// and an 8-bit unsigned-only instance sharing one clock and reset.
module tb_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_is_signed, a_out_valid, a_out_ready, a_dbz, a_busy;
    logic [31:0] a_dividend, a_divisor, a_quotient, a_remainder;

    logic        b_in_valid, b_in_ready, b_is_signed, b_out_valid, b_out_ready, b_dbz, b_busy;
    logic [7:0]  b_dividend, b_divisor, b_quotient, b_remainder;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .dividend(a_dividend), .divisor(a_divisor), .is_signed(a_is_signed),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .quotient(a_quotient), .remainder(a_remainder),
        .div_by_zero(a_dbz), .busy(a_busy)
    );

    div_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .dividend(b_dividend), .divisor(b_divisor), .is_signed(b_is_signed),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .quotient(b_quotient), .remainder(b_remainder),
        .div_by_zero(b_dbz), .busy(b_busy)
    );

    // Drives one operation; lat counts edges after the accept edge until out_valid (-1 on timeout).
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat);
        int guard = 0;
        while (!a_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        a_dividend = a; a_divisor = b; a_is_signed = s; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!a_out_valid) lat = -1;
        q = a_quotient; r = a_remainder; z = a_dbz;
        if (a_out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] q, output logic [7:0] r, output logic z,
                       output int lat);
        int guard = 0;
        while (!b_in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        b_dividend = a; b_divisor = b; b_is_signed = s; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!b_out_valid) lat = -1;
        q = b_quotient; r = b_remainder; z = b_dbz;
        if (b_out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_dividend = '0; a_divisor = '0; a_is_signed = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_dividend = '0; b_divisor = '0; b_is_signed = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_busy, a_dbz} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl32: got %b expected 1000", {a_in_ready, a_out_valid, a_busy, a_dbz});
        end
        checks++;
        if ({a_quotient, a_remainder} !== 64'h0) begin
            errors++; $display("FAIL reset_data32: got %h/%h expected 0/0", a_quotient, a_remainder);
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_busy, b_dbz, b_quotient, b_remainder} !== {4'b1000, 16'h0}) begin
            errors++; $display("FAIL reset8: got %b %h %h expected 1000 00 00",
                               {b_in_ready, b_out_valid, b_busy, b_dbz}, b_quotient, b_remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; logic z; int lat;
        op32(32'd100, 32'd7, 1'b0, q, r, z, lat);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL latency_100_7: got %0d expected 33", lat); end
        checks++;
        if ({q, r, z} !== {32'd14, 32'd2, 1'b0}) begin
            errors++; $display("FAIL udiv_100_7: got q=%0d r=%0d z=%b expected q=14 r=2 z=0", q, r, z);
        end
        op32(32'hFFFFFFF9, 32'd2, 1'b0, q, r, z, lat);
        checks++;
        if ({q, r} !== {32'h7FFFFFFC, 32'd1}) begin
            errors++; $display("FAIL udiv_fff9_2: got q=%h r=%h expected q=7ffffffc r=1", q, r);
        end
        checks++;
        if ({a_in_ready, a_busy, a_out_valid} !== 3'b100) begin
            errors++; $display("FAIL idle_after_consume: got %b expected 100", {a_in_ready, a_busy, a_out_valid});
        end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; logic z; int lat;
        op32(-32'sd7, 32'd2, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL sdiv_m7_2: got q=%h r=%h expected q=fffffffd r=ffffffff", q, r);
        end
        op32(32'd7, -32'sd2, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r} !== {32'hFFFFFFFD, 32'd1}) begin
            errors++; $display("FAIL sdiv_7_m2: got q=%h r=%h expected q=fffffffd r=1", q, r);
        end
        op32(-32'sd100, 32'd7, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r} !== {32'hFFFFFFF2, 32'hFFFFFFFE}) begin
            errors++; $display("FAIL sdiv_m100_7: got q=%h r=%h expected q=fffffff2 r=fffffffe", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic z; int lat;
        op32(32'd5, 32'd0, 1'b0, q, r, z, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        checks++;
        if ({q, r, z} !== {32'hFFFFFFFF, 32'd5, 1'b1}) begin
            errors++; $display("FAIL dz_5_0: got q=%h r=%h z=%b expected q=ffffffff r=5 z=1", q, r, z);
        end
        op32(32'd9, 32'd3, 1'b0, q, r, z, lat);
        checks++;
        if ({q, r, z} !== {32'd3, 32'd0, 1'b0}) begin
            errors++; $display("FAIL after_dz_9_3: got q=%h r=%h z=%b expected q=3 r=0 z=0", q, r, z);
        end
        op32(-32'sd5, 32'd0, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r, z} !== {32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1}) begin
            errors++; $display("FAIL dz_m5_0: got q=%h r=%h z=%b expected q=ffffffff r=fffffffb z=1", q, r, z);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r; logic z; int lat;
        op32(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r, z} !== {32'h80000000, 32'd0, 1'b0}) begin
            errors++; $display("FAIL overflow: got q=%h r=%h z=%b expected q=80000000 r=0 z=0", q, r, z);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q, r; logic z; int lat;
        a_out_ready = 1'b0;
        op32(32'd100, 32'd7, 1'b0, q, r, z, lat);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL bp_latency: got %0d expected 33", lat); end
        for (int i = 0; i < 10; i++) begin
            a_dividend = 32'd55; a_divisor = 32'd5; a_in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({a_out_valid, a_in_ready, a_busy, a_quotient, a_remainder, a_dbz} !== {3'b101, 32'd14, 32'd2, 1'b0}) begin
                errors++; $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b q=%0d r=%0d expected v=1 rdy=0 q=14 r=2",
                                   i, a_out_valid, a_in_ready, a_quotient, a_remainder);
            end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_out_valid, a_in_ready, a_busy} !== 3'b010) begin
            errors++; $display("FAIL bp_release: got %b expected 010", {a_out_valid, a_in_ready, a_busy});
        end
        @(posedge clk); #1;
        checks++;
        if ({a_busy, a_quotient} !== {1'b0, 32'd14}) begin
            errors++; $display("FAIL bp_ignored_input: got busy=%b q=%0d expected busy=0 q=14", a_busy, a_quotient);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] q, r; logic z; int lat;
        a_dividend = 32'd100; a_divisor = 32'd7; a_is_signed = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({a_in_ready, a_out_valid, a_busy, a_dbz, a_quotient, a_remainder} !== {4'b1000, 64'h0}) begin
            errors++; $display("FAIL reset_midop: got %b q=%h r=%h expected 1000 q=0 r=0",
                               {a_in_ready, a_out_valid, a_busy, a_dbz}, a_quotient, a_remainder);
        end
        op32(32'd1000, 32'd10, 1'b0, q, r, z, lat);
        checks++;
        if ({q, r, lat} !== {32'd100, 32'd0, 33}) begin
            errors++; $display("FAIL after_reset_1000_10: got q=%0d r=%0d lat=%0d expected q=100 r=0 lat=33", q, r, lat);
        end
    endtask

    task automatic test_width8();
        logic [7:0] q, r; logic z; int lat;
        op8(8'd100, 8'd7, 1'b0, q, r, z, lat);
        checks++;
        if ({q, r, z, lat} !== {8'd14, 8'd2, 1'b0, 9}) begin
            errors++; $display("FAIL w8_100_7: got q=%0d r=%0d z=%b lat=%0d expected q=14 r=2 z=0 lat=9", q, r, z, lat);
        end
        op8(8'hF9, 8'd2, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r} !== {8'h7C, 8'h01}) begin
            errors++; $display("FAIL w8_f9_2_sgnreq: got q=%h r=%h expected q=7c r=01", q, r);
        end
        op8(8'd7, 8'hFE, 1'b1, q, r, z, lat);
        checks++;
        if ({q, r} !== {8'h00, 8'h07}) begin
            errors++; $display("FAIL w8_7_fe: got q=%h r=%h expected q=00 r=07", q, r);
        end
        op8(8'hF9, 8'd2, 1'b0, q, r, z, lat);
        checks++;
        if ({q, r} !== {8'h7C, 8'h01}) begin
            errors++; $display("FAIL w8_f9_2: got q=%h r=%h expected q=7c r=01", q, r);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
